// File: rtl/genie_pkg.sv
// Shared constants, instruction field positions, opcode and state encodings
// for the genie programmable core.
package genie_pkg;

  localparam int IAW  = 13;
  localparam int DAW  = 26;
  localparam int DW   = 32;
  localparam int NREG = 16;
  localparam int RAW  = 4;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 28;
  localparam int RD_HI  = 27;
  localparam int RD_LO  = 24;
  localparam int RS_HI  = 23;
  localparam int RS_LO  = 20;
  localparam int RT_HI  = 19;
  localparam int RT_LO  = 16;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_LDI    = 4'h1,
    OP_ADD    = 4'h2,
    OP_SUB    = 4'h3,
    OP_MUL    = 4'h4,
    OP_MAC    = 4'h5,
    OP_ADDI   = 4'h6,
    OP_RELU   = 4'h7,
    OP_LD     = 4'h8,
    OP_ST     = 4'h9,
    OP_BEQ    = 4'hA,
    OP_BNE    = 4'hB,
    OP_JMP    = 4'hC,
    OP_RSVD_D = 4'hD,
    OP_RSVD_E = 4'hE,
    OP_HALT   = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_EXEC    = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_WR_REQ  = 3'd4,
    S_HALT    = 3'd5
  } state_e;

  function automatic logic [DW-1:0] sext16(input logic [15:0] v);
    return {{(DW-16){v[15]}}, v};
  endfunction

endpackage

// File: rtl/genie_regfile.sv
// 16x32 register file: three asynchronous read ports, one synchronous write
// port; r0 is never written and always reads as zero.
module genie_regfile
  import genie_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic [RAW-1:0] ra_a,
  input  logic [RAW-1:0] ra_b,
  input  logic [RAW-1:0] ra_c,
  output logic [DW-1:0]  rd_a,
  output logic [DW-1:0]  rd_b,
  output logic [DW-1:0]  rd_c,
  input  logic           we,
  input  logic [RAW-1:0] wa,
  input  logic [DW-1:0]  wd
);

  logic [DW-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd_a = (ra_a == '0) ? '0 : regs[ra_a];
  assign rd_b = (ra_b == '0) ? '0 : regs[ra_b];
  assign rd_c = (ra_c == '0) ? '0 : regs[ra_c];

endmodule

// File: rtl/genie.sv
// Multi-cycle core: fetches from an external synchronous ROM, executes ALU,
// branch and load/store ops against an external valid/ready SRAM port.
//
// state   | meaning
// FETCH   | iaddr holds pc, ROM produces the instruction for next cycle
// EXEC    | decode idata, run ALU/branch, launch LD/ST or halt
// RD_REQ  | rvalid asserted with raddr held until rready
// RD_WAIT | rdata returned, written to the latched destination
// WR_REQ  | wvalid/waddr/wdata held until wready
// HALT    | absorbing; only reset leaves
module genie
  import genie_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  output logic           wvalid,
  input  logic           wready,
  output logic [DAW-1:0] waddr,
  output logic [DW-1:0]  wdata,
  output logic           rvalid,
  input  logic           rready,
  output logic [DAW-1:0] raddr,
  input  logic [DW-1:0]  rdata,
  output logic [IAW-1:0] iaddr,
  input  logic [DW-1:0]  idata
);

  state_e         state, state_d;
  logic [IAW-1:0] pc, pc_d;
  logic           wvalid_d, rvalid_d;
  logic [DAW-1:0] waddr_d, raddr_d;
  logic [DW-1:0]  wdata_d;
  logic [RAW-1:0] ld_rd, ld_rd_d;

  opcode_e        op;
  logic [RAW-1:0] rd_f, rs_f, rt_f;
  logic [15:0]    imm;
  logic [DW-1:0]  simm;
  logic [DW-1:0]  rs_val, rt_val, rd_val;
  logic [DW-1:0]  prod, alu_res;
  logic           alu_we;
  logic [DAW-1:0] mem_addr;
  logic [IAW-1:0] pc_inc, pc_br;

  logic           rf_we;
  logic [RAW-1:0] rf_wa;
  logic [DW-1:0]  rf_wd;

  assign op   = opcode_e'(idata[OP_HI:OP_LO]);
  assign rd_f = idata[RD_HI:RD_LO];
  assign rs_f = idata[RS_HI:RS_LO];
  assign rt_f = idata[RT_HI:RT_LO];
  assign imm  = idata[IMM_HI:IMM_LO];
  assign simm = sext16(imm);

  genie_regfile u_regfile (
    .clk  (clk),
    .rst_n(rst_n),
    .ra_a (rs_f),
    .ra_b (rt_f),
    .ra_c (rd_f),
    .rd_a (rs_val),
    .rd_b (rt_val),
    .rd_c (rd_val),
    .we   (rf_we),
    .wa   (rf_wa),
    .wd   (rf_wd)
  );

  assign prod     = rs_val * rt_val;
  assign mem_addr = rs_val[DAW-1:0] + simm[DAW-1:0];
  assign pc_inc   = pc + 1'b1;
  assign pc_br    = pc_inc + simm[IAW-1:0];

  always_comb begin
    alu_res = '0;
    alu_we  = 1'b1;
    case (op)
      OP_LDI:  alu_res = simm;
      OP_ADD:  alu_res = rs_val + rt_val;
      OP_SUB:  alu_res = rs_val - rt_val;
      OP_MUL:  alu_res = prod;
      OP_MAC:  alu_res = rd_val + prod;
      OP_ADDI: alu_res = rs_val + simm;
      OP_RELU: alu_res = rs_val[DW-1] ? '0 : rs_val;
      default: alu_we  = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state;
    pc_d     = pc;
    wvalid_d = wvalid;
    waddr_d  = waddr;
    wdata_d  = wdata;
    rvalid_d = rvalid;
    raddr_d  = raddr;
    ld_rd_d  = ld_rd;
    rf_we    = 1'b0;
    rf_wa    = rd_f;
    rf_wd    = alu_res;
    case (state)
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        rf_we   = alu_we;
        case (op)
          OP_LD: begin
            state_d  = S_RD_REQ;
            pc_d     = pc;
            rvalid_d = 1'b1;
            raddr_d  = mem_addr;
            ld_rd_d  = rd_f;
          end
          OP_ST: begin
            state_d  = S_WR_REQ;
            pc_d     = pc;
            wvalid_d = 1'b1;
            waddr_d  = mem_addr;
            wdata_d  = rt_val;
          end
          OP_BEQ:  if (rs_val == rt_val) pc_d = pc_br;
          OP_BNE:  if (rs_val != rt_val) pc_d = pc_br;
          OP_JMP:  pc_d = imm[IAW-1:0];
          OP_HALT: begin
            state_d = S_HALT;
            pc_d    = pc;
          end
          default: ;
        endcase
      end
      S_RD_REQ: begin
        if (rready) begin
          rvalid_d = 1'b0;
          state_d  = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        rf_we   = 1'b1;
        rf_wa   = ld_rd;
        rf_wd   = rdata;
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_WR_REQ: begin
        if (wready) begin
          wvalid_d = 1'b0;
          pc_d     = pc_inc;
          state_d  = S_FETCH;
        end
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  // iaddr follows the next pc so the ROM word is ready in EXEC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      pc     <= '0;
      iaddr  <= '0;
      wvalid <= 1'b0;
      waddr  <= '0;
      wdata  <= '0;
      rvalid <= 1'b0;
      raddr  <= '0;
      ld_rd  <= '0;
    end else begin
      state  <= state_d;
      pc     <= pc_d;
      iaddr  <= pc_d;
      wvalid <= wvalid_d;
      waddr  <= waddr_d;
      wdata  <= wdata_d;
      rvalid <= rvalid_d;
      raddr  <= raddr_d;
      ld_rd  <= ld_rd_d;
    end
  end

endmodule

// File: tb/tb_genie.sv
// Self-checking bench for genie: program table with expected SRAM writes,
// plus hand-written write back-pressure and reset-abort sequences.
module tb_genie;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wvalid, rvalid;
  logic        wready = 1'b1;
  logic        rready = 1'b1;
  logic [25:0] waddr, raddr;
  logic [31:0] wdata;
  logic [31:0] rdata = '0;
  logic [12:0] iaddr;
  logic [31:0] idata = '0;

  int errors = 0;
  int checks = 0;

  genie dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wvalid(wvalid),
    .wready(wready),
    .waddr (waddr),
    .wdata (wdata),
    .rvalid(rvalid),
    .rready(rready),
    .raddr (raddr),
    .rdata (rdata),
    .iaddr (iaddr),
    .idata (idata)
  );

  always #5 clk = ~clk;

  logic [31:0] rom  [0:8191];
  logic [31:0] sram [0:255];

  always @(posedge clk) idata <= rom[iaddr];
  always @(posedge clk) if (rvalid && rready) rdata <= sram[raddr[7:0]];

  logic [57:0] obs_q[$];
  logic [57:0] exp_q[$];
  int          hits1 = 0;
  int          n_reads = 0;
  int          both_cnt = 0;
  logic [25:0] last_raddr = '0;
  logic [12:0] prev_iaddr = '0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (wvalid && wready) obs_q.push_back({waddr, wdata});
      if (rvalid && rready) begin
        last_raddr = raddr;
        n_reads++;
      end
      if (wvalid && rvalid) both_cnt++;
      if (iaddr == 13'd1 && prev_iaddr != 13'd1) hits1++;
    end
    prev_iaddr = iaddr;
  end

  typedef struct packed {
    logic [7:0][31:0] code;
    int               ncode;
    int               nw;
    logic [1:0][25:0] wa;
    logic [1:0][31:0] wd;
    int               hits1;
    bit               has_rd;
    logic [25:0]      exp_raddr;
  } prog_t;

  prog_t progs [6];

  function automatic logic [31:0] ins(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [3:0] rt,
                                      input logic [15:0] imm);
    return {op, rd, rs, rt, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_prog(input int p);
    for (int i = 0; i < 16; i++) rom[i] = '0;
    for (int i = 0; i < progs[p].ncode; i++) rom[i] = progs[p].code[i];
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < progs[p].nw; i++) exp_q.push_back({progs[p].wa[i], progs[p].wd[i]});
  endtask

  task automatic wait_halt(input int p);
    int n = 0;
    logic [12:0] hpc;
    hpc = 13'(progs[p].ncode - 1);
    while (iaddr != hpc && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("halt_timeout", 32'(iaddr), 32'(hpc));
    repeat (10) @(negedge clk);
    chk("halt_iaddr", 32'(iaddr), 32'(hpc));
    chk("halt_no_req", {30'd0, wvalid, rvalid}, 32'd0);
  endtask

  task automatic compare_writes(input int p);
    logic [57:0] o, e;
    chk($sformatf("p%0d_nwrites", p), 32'(obs_q.size()), 32'(progs[p].nw));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk($sformatf("p%0d_waddr", p), 32'(o[57:32]), 32'(e[57:32]));
      chk($sformatf("p%0d_wdata", p), o[31:0], e[31:0]);
    end
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int h0, r0;
    logic [25:0] sa;
    logic [31:0] sd;
    int n;

    for (int i = 0; i < 8192; i++) rom[i] = '0;
    for (int i = 0; i < 256; i++) sram[i] = '0;
    sram[100] = 32'h7;

    progs[0] = '0;
    progs[0].code[0] = ins(4'h1, 4'd1, 4'd0, 4'd0, 16'd5);
    progs[0].code[1] = ins(4'h1, 4'd2, 4'd0, 4'd0, 16'hFFFD);
    progs[0].code[2] = ins(4'h2, 4'd3, 4'd1, 4'd2, 16'd0);
    progs[0].code[3] = ins(4'h9, 4'd0, 4'd0, 4'd3, 16'd16);
    progs[0].code[4] = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
    progs[0].ncode = 5; progs[0].nw = 1; progs[0].hits1 = 1;
    progs[0].wa[0] = 26'd16; progs[0].wd[0] = 32'd2;

    progs[1] = '0;
    progs[1].code[0] = ins(4'h1, 4'd1, 4'd0, 4'd0, 16'd100);
    progs[1].code[1] = ins(4'h8, 4'd4, 4'd1, 4'd0, 16'd0);
    progs[1].code[2] = ins(4'h4, 4'd5, 4'd4, 4'd4, 16'd0);
    progs[1].code[3] = ins(4'h9, 4'd0, 4'd0, 4'd5, 16'd0);
    progs[1].code[4] = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
    progs[1].ncode = 5; progs[1].nw = 1; progs[1].hits1 = 1;
    progs[1].wa[0] = 26'd0; progs[1].wd[0] = 32'd49;
    progs[1].has_rd = 1'b1; progs[1].exp_raddr = 26'd100;

    progs[2] = '0;
    progs[2].code[0] = ins(4'h1, 4'd1, 4'd0, 4'd0, 16'd3);
    progs[2].code[1] = ins(4'h6, 4'd1, 4'd1, 4'd0, 16'hFFFF);
    progs[2].code[2] = ins(4'hB, 4'd0, 4'd1, 4'd0, 16'hFFFE);
    progs[2].code[3] = ins(4'h9, 4'd0, 4'd0, 4'd1, 16'd0);
    progs[2].code[4] = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
    progs[2].ncode = 5; progs[2].nw = 1; progs[2].hits1 = 3;
    progs[2].wa[0] = 26'd0; progs[2].wd[0] = 32'd0;

    progs[3] = '0;
    progs[3].code[0] = ins(4'h1, 4'd1, 4'd0, 4'd0, 16'hFFFC);
    progs[3].code[1] = ins(4'h1, 4'd2, 4'd0, 4'd0, 16'd2);
    progs[3].code[2] = ins(4'h1, 4'd3, 4'd0, 4'd0, 16'd10);
    progs[3].code[3] = ins(4'h5, 4'd3, 4'd1, 4'd2, 16'd0);
    progs[3].code[4] = ins(4'h7, 4'd6, 4'd1, 4'd0, 16'd0);
    progs[3].code[5] = ins(4'h9, 4'd0, 4'd0, 4'd3, 16'd1);
    progs[3].code[6] = ins(4'h9, 4'd0, 4'd0, 4'd6, 16'd2);
    progs[3].code[7] = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
    progs[3].ncode = 8; progs[3].nw = 2; progs[3].hits1 = 1;
    progs[3].wa[0] = 26'd1; progs[3].wd[0] = 32'd2;
    progs[3].wa[1] = 26'd2; progs[3].wd[1] = 32'd0;

    progs[4] = '0;
    progs[4].code[0] = ins(4'h1, 4'd0, 4'd0, 4'd0, 16'd9);
    progs[4].code[1] = ins(4'h9, 4'd0, 4'd0, 4'd0, 16'd5);
    progs[4].code[2] = ins(4'h1, 4'd1, 4'd0, 4'd0, 16'd7);
    progs[4].code[3] = ins(4'h7, 4'd2, 4'd1, 4'd0, 16'd0);
    progs[4].code[4] = ins(4'h9, 4'd0, 4'd0, 4'd2, 16'd6);
    progs[4].code[5] = ins(4'hD, 4'd3, 4'd1, 4'd1, 16'd0);
    progs[4].code[6] = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
    progs[4].ncode = 7; progs[4].nw = 2; progs[4].hits1 = 1;
    progs[4].wa[0] = 26'd5; progs[4].wd[0] = 32'd0;
    progs[4].wa[1] = 26'd6; progs[4].wd[1] = 32'd7;

    progs[5] = '0;
    progs[5].code[0] = ins(4'h1, 4'd1, 4'd0, 4'd0, 16'd7);
    progs[5].code[1] = ins(4'hA, 4'd0, 4'd1, 4'd1, 16'd1);
    progs[5].code[2] = ins(4'h1, 4'd1, 4'd0, 4'd0, 16'd1);
    progs[5].code[3] = ins(4'hC, 4'd0, 4'd0, 4'd0, 16'd5);
    progs[5].code[4] = ins(4'h1, 4'd1, 4'd0, 4'd0, 16'd2);
    progs[5].code[5] = ins(4'h3, 4'd2, 4'd0, 4'd1, 16'd0);
    progs[5].code[6] = ins(4'h9, 4'd0, 4'd0, 4'd2, 16'hFFFF);
    progs[5].code[7] = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
    progs[5].ncode = 8; progs[5].nw = 1; progs[5].hits1 = 1;
    progs[5].wa[0] = 26'h3FFFFFF; progs[5].wd[0] = 32'hFFFFFFF9;

    repeat (3) @(negedge clk);
    chk("rst_wvalid", {31'd0, wvalid}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_iaddr", 32'(iaddr), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_raddr", 32'(raddr), 32'd0);
    chk("rst_wdata", wdata, 32'd0);

    for (int p = 0; p < 6; p++) begin
      rst_n = 1'b0;
      load_prog(p);
      h0 = hits1;
      release_reset();
      wait_halt(p);
      compare_writes(p);
      chk($sformatf("p%0d_hits1", p), 32'(hits1 - h0), 32'(progs[p].hits1));
      if (progs[p].has_rd) chk($sformatf("p%0d_raddr", p), 32'(last_raddr), 32'(progs[p].exp_raddr));
    end

    // write back-pressure: wready low for 20 cycles during the ST
    rst_n = 1'b0;
    load_prog(0);
    wready = 1'b0;
    release_reset();
    n = 0;
    while (!wvalid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("stall_wvalid_seen", {31'd0, wvalid}, 32'd1);
    sa = waddr;
    sd = wdata;
    chk("stall_waddr", 32'(sa), 32'd16);
    chk("stall_wdata", sd, 32'd2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_hold", {wvalid, rvalid, waddr, wdata[3:0]}, {1'b1, 1'b0, sa, sd[3:0]});
      chk("stall_hold_wdata", wdata, sd);
    end
    chk("stall_no_write", 32'(obs_q.size()), 32'd0);
    wready = 1'b1;
    wait_halt(0);
    compare_writes(0);

    // reset while a read is stalled in RD_REQ
    rst_n = 1'b0;
    load_prog(1);
    rready = 1'b0;
    release_reset();
    n = 0;
    while (!rvalid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort_rvalid_seen", {31'd0, rvalid}, 32'd1);
    chk("abort_raddr", 32'(raddr), 32'd100);
    repeat (3) @(negedge clk);
    r0 = n_reads;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_rvalid", {31'd0, rvalid}, 32'd0);
    chk("abort_iaddr", 32'(iaddr), 32'd0);
    rready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_halt(1);
    compare_writes(1);
    chk("abort_nreads", 32'(n_reads - r0), 32'd1);

    chk("never_both_valid", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
